axil_regfile: RTL and testbench

//  Parametrised AXI4-Lite control/status register file: NREG registers of DATA_W bits on the cbus slave port.

---
 rtl/axil_pkg.sv | 15 +
 rtl/axil_regfile_slot.sv | 39 +++
 rtl/axil_regfile.sv | 248 ++++++++++++++++++++++++
 tb/tb_axil_regfile.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared response codes, FSM state types and sizing helper for the AXI4-Lite register file.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

    // Register index width; a single-register file still decodes one index bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axil_regfile_slot.sv
// One register of the file: byte-strobe merge, read-only gate, bus-over-hardware priority.
module axil_regfile_slot #(
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter bit                RO        = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bus_we,
    input  logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W/8-1:0] bus_wstrb,
    input  logic                hw_valid,
    input  logic [DATA_W-1:0]   hw_data,
    output logic [DATA_W-1:0]   q
);

    localparam int unsigned NBYTE = DATA_W / 8;

    logic [DATA_W-1:0] merged;

    always_comb begin
        merged = q;
        for (int unsigned b = 0; b < NBYTE; b++) begin
            if (bus_wstrb[b]) merged[b*8 +: 8] = bus_wdata[b*8 +: 8];
        end
    end

    // A bus commit in the same cycle as a hardware set wins; the hardware value is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (bus_we && !RO) begin
            q <= merged;
        end else if (hw_valid) begin
            q <= hw_data;
        end
    end

endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite control/status register file with byte strobes, read-only masking and a hardware set port.
// Define AXIL_REGFILE_WPULSE_EN to add reg_wpulse, a one-cycle strobe per successful bus write.
module axil_regfile
    import axil_pkg::*;
#(
    parameter int unsigned       NREG      = 4,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       ADDR_LSB  = 0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter logic [NREG-1:0]   RO_MASK   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      cbus_awaddr,
    input  logic [2:0]             cbus_awprot,
    input  logic                   cbus_awvalid,
    output logic                   cbus_awready,
    input  logic [DATA_W-1:0]      cbus_wdata,
    input  logic [DATA_W/8-1:0]    cbus_wstrb,
    input  logic                   cbus_wvalid,
    output logic                   cbus_wready,
    output logic [1:0]             cbus_bresp,
    output logic                   cbus_bvalid,
    input  logic                   cbus_bready,
    input  logic [ADDR_W-1:0]      cbus_araddr,
    input  logic [2:0]             cbus_arprot,
    input  logic                   cbus_arvalid,
    output logic                   cbus_arready,
    output logic [DATA_W-1:0]      cbus_rdata,
    output logic [1:0]             cbus_rresp,
    output logic                   cbus_rvalid,
    input  logic                   cbus_rready,
    output logic [NREG*DATA_W-1:0] reg_q,
    input  logic [NREG-1:0]        hw_set_valid,
    input  logic [NREG*DATA_W-1:0] hw_set_data
`ifdef AXIL_REGFILE_WPULSE_EN
    ,
    output logic [NREG-1:0]        reg_wpulse
`endif
);

    localparam int unsigned IDX_W    = idx_width(NREG);
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned UPPER_SH = ADDR_LSB + IDX_W;

    // Out of range: any address bit above the index field, or an index past the last register.
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] upper;
        upper = a >> UPPER_SH;
        return (upper != '0) || (32'(a[ADDR_LSB +: IDX_W]) >= NREG);
    endfunction

    logic unused_prot;
    assign unused_prot = ^{cbus_awprot, cbus_arprot};

    wr_state_e           wr_state, wr_state_n;
    logic                aw_held, aw_held_n, w_held, w_held_n;
    logic                awready_n, wready_n, bvalid_n;
    logic [1:0]          bresp_n;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [STRB_W-1:0]   w_strb_q;

    logic                aw_hs, w_hs, wr_commit, wr_err, ro_hit, wr_ok;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [STRB_W-1:0]   wr_strb;
    logic [IDX_W-1:0]    wr_idx;
    logic [NREG-1:0]     bus_we;

    // The commit may use a beat accepted on this very edge, so select live vs held payloads.
    always_comb begin
        aw_hs     = cbus_awvalid && cbus_awready;
        w_hs      = cbus_wvalid && cbus_wready;
        wr_addr   = aw_hs ? cbus_awaddr : aw_addr_q;
        wr_data   = w_hs ? cbus_wdata : w_data_q;
        wr_strb   = w_hs ? cbus_wstrb : w_strb_q;
        wr_idx    = wr_addr[ADDR_LSB +: IDX_W];
        wr_err    = addr_err(wr_addr);
        wr_commit = (wr_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
        ro_hit    = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (wr_idx == IDX_W'(i)) ro_hit = RO_MASK[i];
        end
        wr_ok  = !wr_err && !ro_hit;
        bus_we = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            bus_we[i] = wr_commit && wr_ok && (wr_idx == IDX_W'(i));
        end
    end

    always_comb begin
        wr_state_n = wr_state;
        aw_held_n  = aw_held;
        w_held_n   = w_held;
        awready_n  = cbus_awready;
        wready_n   = cbus_wready;
        bvalid_n   = cbus_bvalid;
        bresp_n    = cbus_bresp;
        case (wr_state)
            W_IDLE: begin
                if (aw_hs) aw_held_n = 1'b1;
                if (w_hs)  w_held_n  = 1'b1;
                if (wr_commit) begin
                    wr_state_n = W_RESP;
                    aw_held_n  = 1'b0;
                    w_held_n   = 1'b0;
                    awready_n  = 1'b0;
                    wready_n   = 1'b0;
                    bvalid_n   = 1'b1;
                    bresp_n    = wr_ok ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    awready_n = !aw_held_n;
                    wready_n  = !w_held_n;
                end
            end
            W_RESP: begin
                if (cbus_bready) begin
                    wr_state_n = W_IDLE;
                    bvalid_n   = 1'b0;
                    awready_n  = 1'b1;
                    wready_n   = 1'b1;
                end
            end
            default: wr_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state     <= W_IDLE;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            cbus_awready <= 1'b0;
            cbus_wready  <= 1'b0;
            cbus_bvalid  <= 1'b0;
            cbus_bresp   <= RESP_OKAY;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
        end else begin
            wr_state     <= wr_state_n;
            aw_held      <= aw_held_n;
            w_held       <= w_held_n;
            cbus_awready <= awready_n;
            cbus_wready  <= wready_n;
            cbus_bvalid  <= bvalid_n;
            cbus_bresp   <= bresp_n;
            if (aw_hs) aw_addr_q <= cbus_awaddr;
            if (w_hs) begin
                w_data_q <= cbus_wdata;
                w_strb_q <= cbus_wstrb;
            end
        end
    end

    rd_state_e         rd_state, rd_state_n;
    logic              arready_n, rvalid_n;
    logic [1:0]        rresp_n;
    logic [DATA_W-1:0] rdata_n, rd_word;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_err, ar_hs;

    // Read mux samples current register state, so a same-edge write is not yet visible.
    always_comb begin
        ar_hs   = cbus_arvalid && cbus_arready;
        rd_idx  = cbus_araddr[ADDR_LSB +: IDX_W];
        rd_err  = addr_err(cbus_araddr);
        rd_word = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (rd_idx == IDX_W'(i)) rd_word = reg_q[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        rd_state_n = rd_state;
        arready_n  = cbus_arready;
        rvalid_n   = cbus_rvalid;
        rresp_n    = cbus_rresp;
        rdata_n    = cbus_rdata;
        case (rd_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (ar_hs) begin
                    rd_state_n = R_DATA;
                    arready_n  = 1'b0;
                    rvalid_n   = 1'b1;
                    rdata_n    = rd_err ? '0 : rd_word;
                    rresp_n    = rd_err ? RESP_SLVERR : RESP_OKAY;
                end
            end
            R_DATA: begin
                if (cbus_rready) begin
                    rd_state_n = R_IDLE;
                    rvalid_n   = 1'b0;
                    arready_n  = 1'b1;
                end
            end
            default: rd_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state     <= R_IDLE;
            cbus_arready <= 1'b0;
            cbus_rvalid  <= 1'b0;
            cbus_rresp   <= RESP_OKAY;
            cbus_rdata   <= '0;
        end else begin
            rd_state     <= rd_state_n;
            cbus_arready <= arready_n;
            cbus_rvalid  <= rvalid_n;
            cbus_rresp   <= rresp_n;
            cbus_rdata   <= rdata_n;
        end
    end

    for (genvar i = 0; i < NREG; i++) begin : g_slot
        axil_regfile_slot #(
            .DATA_W    (DATA_W),
            .RESET_VAL (RESET_VAL),
            .RO        (RO_MASK[i])
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .bus_we    (bus_we[i]),
            .bus_wdata (wr_data),
            .bus_wstrb (wr_strb),
            .hw_valid  (hw_set_valid[i]),
            .hw_data   (hw_set_data[i*DATA_W +: DATA_W]),
            .q         (reg_q[i*DATA_W +: DATA_W])
        );
    end

`ifdef AXIL_REGFILE_WPULSE_EN
    // Rises with bvalid: bus_we is only set on the commit edge of an OKAY write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_wpulse <= '0;
        end else begin
            reg_wpulse <= bus_we;
        end
    end
`endif

endmodule

// File: tb/tb_axil_regfile.sv
// Self-checking bench for axil_regfile: vector table, randomized ops against a word-array model,
// and hand sequences for handshake ordering, collisions and reset mid-transaction.
module tb_axil_regfile;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [3:0] ROM    = 4'b0100;
    localparam int OP_WR = 0, OP_RD = 1, OP_HW = 2, OP_RST = 3;

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  awaddr = '0, wdata = '0, araddr = '0;
    logic [2:0]   awprot = '0, arprot = '0;
    logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [3:0]   wstrb = '0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [127:0] reg_q;
    logic [3:0]   hw_valid = '0;
    logic [127:0] hw_data = '0;
`ifdef AXIL_REGFILE_WPULSE_EN
    logic [3:0]   wpulse;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [4];

    always #5 clk = ~clk;

    axil_regfile #(
        .NREG(4), .DATA_W(32), .ADDR_W(32), .ADDR_LSB(0), .RESET_VAL(32'h0), .RO_MASK(ROM)
    ) dut (
        .clk(clk), .rst(rst),
        .cbus_awaddr(awaddr), .cbus_awprot(awprot), .cbus_awvalid(awvalid), .cbus_awready(awready),
        .cbus_wdata(wdata), .cbus_wstrb(wstrb), .cbus_wvalid(wvalid), .cbus_wready(wready),
        .cbus_bresp(bresp), .cbus_bvalid(bvalid), .cbus_bready(bready),
        .cbus_araddr(araddr), .cbus_arprot(arprot), .cbus_arvalid(arvalid), .cbus_arready(arready),
        .cbus_rdata(rdata), .cbus_rresp(rresp), .cbus_rvalid(rvalid), .cbus_rready(rready),
        .reg_q(reg_q), .hw_set_valid(hw_valid), .hw_set_data(hw_data)
`ifdef AXIL_REGFILE_WPULSE_EN
        , .reg_wpulse(wpulse)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a plain word array; legal addresses are 0..3, RO words reject bus writes.
    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        if (a > 32'd3) return SLVERR;
        if (ROM[a[1:0]]) return SLVERR;
        for (int b = 0; b < 4; b++) if (s[b]) mem[a[1:0]][b*8 +: 8] = d[b*8 +: 8];
        return OKAY;
    endfunction

    function automatic logic [1:0] model_read(input logic [31:0] a, output logic [31:0] d);
        if (a > 32'd3) begin
            d = '0;
            return SLVERR;
        end
        d = mem[a[1:0]];
        return OKAY;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) check({tag, "_reg_q"}, reg_q[i*32 +: 32], mem[i]);
    endtask

    task automatic check_pulse(input string name, input logic [3:0] exp);
`ifdef AXIL_REGFILE_WPULSE_EN
        check(name, 32'(wpulse), 32'(exp));
`else
        if (exp !== exp) $display("unreachable %s", name);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; hw_valid = '0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        tick();
        check("rst_ready", 32'({awready, wready, arready}), 32'h0);
        check("rst_valid", 32'({bvalid, rvalid}), 32'h0);
        check("rst_resp", 32'({bresp, rresp}), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check_pulse("rst_wpulse", 4'h0);
        check_regs("rst");
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'({awready, wready, arready}), 32'h7);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] exp);
        logic aw_done, w_done, aw_now, w_now;
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1; wvalid = 1; bready = 1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_now = awready;
            w_now  = wready;
            tick();
            if (aw_now && !aw_done) begin aw_done = 1; awvalid = 0; end
            if (w_now && !w_done)   begin w_done = 1;  wvalid = 0; end
            n++;
        end
        awvalid = 0; wvalid = 0;
        if (!(aw_done && w_done)) check("wr_handshake_timeout", 32'h0, 32'h1);
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        check("wr_bvalid", 32'(bvalid), 32'h1);
        check("wr_bresp", 32'(bresp), 32'(exp));
        check_pulse("wr_wpulse", (exp == OKAY) ? 4'(4'b1 << a[1:0]) : 4'h0);
        tick();
        bready = 0;
        check("wr_bvalid_drop", 32'(bvalid), 32'h0);
        check_pulse("wr_wpulse_drop", 4'h0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [1:0] exp_resp, input logic [31:0] exp_data);
        int n;
        araddr = a; arvalid = 1; rready = 1; n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        tick();
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        check("rd_rvalid", 32'(rvalid), 32'h1);
        check("rd_rresp", 32'(rresp), 32'(exp_resp));
        check("rd_rdata", rdata, exp_data);
        tick();
        rready = 0;
        check("rd_rvalid_drop", 32'(rvalid), 32'h0);
    endtask

    task automatic do_hw(input int idx, input logic [31:0] d);
        hw_data = '0;
        hw_data[idx*32 +: 32] = d;
        hw_valid = 4'(1 << idx);
        tick();
        hw_valid = '0;
        mem[idx] = d;
        check_pulse("hw_wpulse", 4'h0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [1:0]  r;
        logic [31:0] d, a, old;
        logic [3:0]  s;

        vecs.push_back('{OP_WR, 32'h0,   32'hFFFF_FFFF, 4'hF, OKAY,   32'h0});
        vecs.push_back('{OP_WR, 32'h1,   32'hFFFF_FFFF, 4'hF, OKAY,   32'h0});
        vecs.push_back('{OP_WR, 32'h2,   32'hFFFF_FFFF, 4'hF, SLVERR, 32'h0});
        vecs.push_back('{OP_WR, 32'h3,   32'hFFFF_FFFF, 4'hF, OKAY,   32'h0});
        vecs.push_back('{OP_HW, 32'h2,   32'hFFFF_FFFF, 4'h0, OKAY,   32'h0});
        vecs.push_back('{OP_RD, 32'h0,   32'h0,         4'h0, OKAY,   32'hFFFF_FFFF});
        vecs.push_back('{OP_RD, 32'h1,   32'h0,         4'h0, OKAY,   32'hFFFF_FFFF});
        vecs.push_back('{OP_RD, 32'h2,   32'h0,         4'h0, OKAY,   32'hFFFF_FFFF});
        vecs.push_back('{OP_RD, 32'h3,   32'h0,         4'h0, OKAY,   32'hFFFF_FFFF});
        vecs.push_back('{OP_RST, 32'h0,  32'h0,         4'h0, OKAY,   32'h0});
        vecs.push_back('{OP_WR, 32'h1,   32'h1234_5678, 4'h5, OKAY,   32'h0});
        vecs.push_back('{OP_RD, 32'h1,   32'h0,         4'h0, OKAY,   32'h0034_0078});
        vecs.push_back('{OP_WR, 32'h4,   32'hDEAD_BEEF, 4'hF, SLVERR, 32'h0});
        vecs.push_back('{OP_RD, 32'h4,   32'h0,         4'h0, SLVERR, 32'h0});
        vecs.push_back('{OP_RD, 32'h1,   32'h0,         4'h0, OKAY,   32'h0034_0078});
        vecs.push_back('{OP_WR, 32'h100, 32'hDEAD_BEEF, 4'hF, SLVERR, 32'h0});
        vecs.push_back('{OP_RD, 32'h101, 32'h0,         4'h0, SLVERR, 32'h0});
        vecs.push_back('{OP_WR, 32'h0,   32'hAAAA_AAAA, 4'h0, OKAY,   32'h0});
        vecs.push_back('{OP_RD, 32'h0,   32'h0,         4'h0, OKAY,   32'h0});
        vecs.push_back('{OP_WR, 32'h3,   32'h1122_3344, 4'h8, OKAY,   32'h0});
        vecs.push_back('{OP_RD, 32'h3,   32'h0,         4'h0, OKAY,   32'h1100_0000});

        do_reset();

        foreach (vecs[k]) begin
            case (vecs[k].op)
                OP_WR: begin
                    r = model_write(vecs[k].addr, vecs[k].data, vecs[k].strb);
                    do_write(vecs[k].addr, vecs[k].data, vecs[k].strb, vecs[k].resp);
                end
                OP_RD:  do_read(vecs[k].addr, vecs[k].resp, vecs[k].rdata);
                OP_HW:  do_hw(int'(vecs[k].addr), vecs[k].data);
                default: do_reset();
            endcase
            check_regs("vec");
        end

        // Read-only register: bus write refused, hardware set still lands.
        do_write(32'h2, 32'h0000_00A5, 4'hF, SLVERR);
        check("ro_unchanged", reg_q[64 +: 32], mem[2]);
        do_hw(2, 32'h0000_005A);
        do_read(32'h2, OKAY, 32'h0000_005A);

        // W arrives three cycles ahead of AW; response held while bready stays low.
        bready = 0;
        wdata = 32'hCAFE_0003; wstrb = 4'hF; wvalid = 1;
        check("w_first_wready", 32'(wready), 32'h1);
        tick();
        wvalid = 0;
        for (int c = 0; c < 2; c++) begin
            check("w_held_wready", 32'(wready), 32'h0);
            check("w_held_no_b", 32'(bvalid), 32'h0);
            check("w_held_no_commit", reg_q[96 +: 32], mem[3]);
            tick();
        end
        check("aw_late_awready", 32'(awready), 32'h1);
        awaddr = 32'h3; awvalid = 1;
        tick();
        awvalid = 0;
        r = model_write(32'h3, 32'hCAFE_0003, 4'hF);
        for (int c = 0; c < 5; c++) begin
            check("bhold_bvalid", 32'(bvalid), 32'h1);
            check("bhold_bresp", 32'(bresp), 32'(OKAY));
            check("bhold_readies", 32'({awready, wready}), 32'h0);
            check("bhold_reg3", reg_q[96 +: 32], mem[3]);
            check_pulse("bhold_wpulse", (c == 0) ? 4'b1000 : 4'h0);
            tick();
        end
        bready = 1;
        tick();
        bready = 0;
        check("bhold_release", 32'(bvalid), 32'h0);
        check("bhold_ready_back", 32'({awready, wready}), 32'h3);

        // Hardware set and bus commit hit reg0 on the same edge: bus wins.
        check("coll_ready", 32'({awready, wready}), 32'h3);
        awaddr = 32'h0; wdata = 32'h22; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        hw_data = '0; hw_data[31:0] = 32'h11; hw_valid = 4'b0001;
        tick();
        awvalid = 0; wvalid = 0; hw_valid = '0;
        r = model_write(32'h0, 32'h22, 4'hF);
        check("coll_bvalid", 32'(bvalid), 32'h1);
        check("coll_reg0", reg_q[31:0], 32'h22);
        check_pulse("coll_wpulse", 4'b0001);
        tick();
        bready = 0;
        check("coll_reg0_stays", reg_q[31:0], 32'h22);
        check_pulse("coll_wpulse_drop", 4'h0);

        // Read accepted on the write commit edge returns the pre-write value.
        old = mem[1];
        check("rw_ready", 32'({arready, awready, wready}), 32'h7);
        araddr = 32'h1; arvalid = 1; rready = 1;
        awaddr = 32'h1; wdata = 32'h5555_AAAA; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        tick();
        arvalid = 0; awvalid = 0; wvalid = 0;
        r = model_write(32'h1, 32'h5555_AAAA, 4'hF);
        check("rw_rdata_old", rdata, old);
        check("rw_reg1_new", reg_q[63:32], 32'h5555_AAAA);
        check("rw_both_valid", 32'({rvalid, bvalid}), 32'h3);
        tick();
        rready = 0; bready = 0;

        // Reset after a lone W beat discards it; a later AW alone must not commit.
        wdata = 32'h0BAD_0BAD; wstrb = 4'hF; wvalid = 1;
        tick();
        wvalid = 0;
        do_reset();
        awaddr = 32'h0; awvalid = 1;
        tick();
        awvalid = 0;
        for (int c = 0; c < 3; c++) begin
            check("rst_discard_no_b", 32'(bvalid), 32'h0);
            tick();
        end
        wdata = 32'h77; wstrb = 4'hF; wvalid = 1;
        tick();
        wvalid = 0;
        r = model_write(32'h0, 32'h77, 4'hF);
        check("rst_discard_b", 32'(bvalid), 32'h1);
        bready = 1;
        tick();
        bready = 0;
        check_regs("rst_discard");

        // Randomized traffic against the model.
        for (int it = 0; it < 150; it++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            a = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 5));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if (kind < 4) begin
                r = model_write(a, d, s);
                do_write(a, d, s, r);
            end else if (kind < 8) begin
                logic [31:0] ed;
                r = model_read(a, ed);
                do_read(a, r, ed);
            end else begin
                do_hw(int'($urandom_range(0, 3)), d);
            end
            check_regs("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
